// File: rtl/bus_term_pkg.sv
// -----------------------------------------------------------------------------
// bus_term_pkg
// Shared constants, types and small helpers for the bus terminal adapter.
//   ID_W       width of the destination ID that heads every packet
//   pkt16_t    view of a default-width (16-bit) packet: {dest, payload}
//   cnt_width  occupancy counter width for a FIFO of a given depth
//   ptr_width  read/write pointer width for a FIFO of a given depth
//   dest_id    extracts D[pkt_w-1 -: ID_W] from a packet of width pkt_w
// -----------------------------------------------------------------------------
package bus_term_pkg;

    localparam int ID_W      = 8;
    localparam int PKT_MAX_W = 64;

    typedef logic [PKT_MAX_W-1:0] pkt_max_t;

    typedef struct packed {
        logic [ID_W-1:0] dest;
        logic [7:0]      payload;
    } pkt16_t;

    // Counter must be able to hold the value 'depth' itself, hence depth+1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Packets narrower than PKT_MAX_W are passed zero-extended.
    function automatic logic [ID_W-1:0] dest_id(input pkt_max_t pkt, input int pkt_w);
        pkt_max_t shifted;
        shifted = pkt >> (pkt_w - ID_W);
        return shifted[ID_W-1:0];
    endfunction

endpackage

// File: rtl/bus_term_sync_fifo.sv
// -----------------------------------------------------------------------------
// bus_term_sync_fifo
// Single-clock first-word-fall-through FIFO used for both the TX and RX
// directions of a bus terminal.
//   clk, reset   clock, asynchronous active-low reset
//   wr_en        write strobe; accepted when not full, or when full and a
//                read happens in the same cycle
//   wr_data      data to write
//   rd_en        read strobe; ignored when empty
//   rd_data      head entry (combinational from storage, valid when not_empty)
//   not_empty    registered count != 0
//   full         registered count == depth
//   count        occupancy
//   ovf          one-cycle pulse after a dropped write
// depth must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module bus_term_sync_fifo
    import bus_term_pkg::*;
#(
    parameter  int width = 16,
    parameter  int depth = 8,
    localparam int CW    = cnt_width(depth),
    localparam int PW    = ptr_width(depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [width-1:0] wr_data,
    input  logic             rd_en,
    output logic [width-1:0] rd_data,
    output logic             not_empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             ovf
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(depth);

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             rd_fire;
    logic             wr_fire;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // A read on an empty FIFO is ignored; a read on a full FIFO frees the
        // slot that a same-cycle write then reuses.
        rd_fire = rd_en && (count_q != '0);
        wr_fire = wr_en && ((count_q != FULL_COUNT) || rd_fire);

        if (wr_fire) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (wr_fire && !rd_fire) begin
            count_d = count_q + CW'(1);
        end else if (!wr_fire && rd_fire) begin
            count_d = count_q - CW'(1);
        end

        ovf_d = wr_en && !wr_fire;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: storage is reset too, so the fall-through head reads 0
            // (never X) right after reset, including a mid-operation reset.
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its inputs, independent of statement order.
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rd_data   = mem_q[rd_ptr_q];
    assign not_empty = (count_q != '0);
    assign full      = (count_q == FULL_COUNT);
    assign count     = count_q;
    assign ovf       = ovf_q;

endmodule

// File: rtl/bus_terminal_fifo.sv
// -----------------------------------------------------------------------------
// bus_terminal_fifo
// Per-terminal adapter between one device and one terminal of the bus
// generator/arbiter. One instance per terminal.
//   TX: device writes with tx_push/tx_data; the bus sees pndng/D_pop (head,
//       fall-through) and consumes it with pop.
//   RX: the bus delivers with push/D_push; the device sees rx_pndng/rx_data
//       and consumes with rx_pop.
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   tx_push, tx_data      device enqueue
//   tx_full, tx_count     TX status
//   pndng, D_pop, pop     bus side of the TX FIFO
//   push, D_push          bus side of the RX FIFO
//   rx_pop, rx_data       device side of the RX FIFO
//   rx_pndng, rx_count    RX status
//   tx_ovf, rx_ovf        one-cycle pulse after a dropped write
// Optional build macro BUS_TERM_STATS_EN adds:
//   tx_drop_cnt, rx_drop_cnt  saturating 16-bit counts of ovf pulses
//   tx_pop_err                one-cycle pulse after a bus pop on empty TX
// Packets pass through untouched; the destination field D[pckg_sz-1 -: 8]
// is not interpreted here.
// -----------------------------------------------------------------------------
module bus_terminal_fifo
    import bus_term_pkg::*;
#(
    parameter  int pckg_sz = 16,
    parameter  int depth   = 8,
    localparam int CW      = cnt_width(depth)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_push,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic [CW-1:0]      tx_count,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               rx_pop,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_pndng,
    output logic [CW-1:0]      rx_count,
    output logic               tx_ovf,
    output logic               rx_ovf
`ifdef BUS_TERM_STATS_EN
    ,
    output logic [15:0]        tx_drop_cnt,
    output logic [15:0]        rx_drop_cnt,
    output logic               tx_pop_err
`endif
);

    bus_term_sync_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (tx_push),
        .wr_data   (tx_data),
        .rd_en     (pop),
        .rd_data   (D_pop),
        .not_empty (pndng),
        .full      (tx_full),
        .count     (tx_count),
        .ovf       (tx_ovf)
    );

    // RX full status is not exported; a bus push into a full RX FIFO is
    // reported only through rx_ovf.
    logic rx_full_unused;

    bus_term_sync_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (push),
        .wr_data   (D_push),
        .rd_en     (rx_pop),
        .rd_data   (rx_data),
        .not_empty (rx_pndng),
        .full      (rx_full_unused),
        .count     (rx_count),
        .ovf       (rx_ovf)
    );

`ifdef BUS_TERM_STATS_EN
    logic [15:0] tx_drop_cnt_q, tx_drop_cnt_d;
    logic [15:0] rx_drop_cnt_q, rx_drop_cnt_d;
    logic        tx_pop_err_q,  tx_pop_err_d;

    always_comb begin
        tx_drop_cnt_d = tx_drop_cnt_q;
        rx_drop_cnt_d = rx_drop_cnt_q;
        // Counters follow the registered ovf pulses, so they lag them by one
        // cycle; they stick at all-ones instead of wrapping.
        if (tx_ovf && (tx_drop_cnt_q != 16'hFFFF)) begin
            tx_drop_cnt_d = tx_drop_cnt_q + 16'd1;
        end
        if (rx_ovf && (rx_drop_cnt_q != 16'hFFFF)) begin
            rx_drop_cnt_d = rx_drop_cnt_q + 16'd1;
        end
        tx_pop_err_d = pop && !pndng;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_drop_cnt_q <= '0;
            rx_drop_cnt_q <= '0;
            tx_pop_err_q  <= 1'b0;
        end else begin
            tx_drop_cnt_q <= tx_drop_cnt_d;
            rx_drop_cnt_q <= rx_drop_cnt_d;
            tx_pop_err_q  <= tx_pop_err_d;
        end
    end

    assign tx_drop_cnt = tx_drop_cnt_q;
    assign rx_drop_cnt = rx_drop_cnt_q;
    assign tx_pop_err  = tx_pop_err_q;
`endif

endmodule
